// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit (shift-add multiply, restoring divide)
// Optional MULDIV_FAST_MUL_EN: multiplies finish in one cycle; divides stay iterative.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e              state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [2:0]          f3_q, f3_d;
  logic                neg_q, neg_d;
  logic                sgna_q, sgna_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                signed_a, signed_b, sign_a, sign_b;
  logic                is_div, div_zero, div_ovf;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic [XLEN:0]       mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0]   mul_step, div_step;

  // acc holds {product_hi, product_lo} for multiply and {remainder, quotient} for divide.
  function automatic logic [XLEN-1:0] finalize(input logic [2:0] f3, input logic [2*XLEN-1:0] acc,
                                                input logic neg, input logic sgna);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    prod = neg ? -acc : acc;
    quo  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = sgna ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (!f3[2]) finalize = (f3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else        finalize = f3[1] ? rem : quo;
  endfunction

  always_comb begin
    signed_a = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    signed_b = signed_a && (funct3 != 3'b010);
    sign_a   = signed_a && op_a[XLEN-1];
    sign_b   = signed_b && op_b[XLEN-1];
    mag_a    = sign_a ? -op_a : op_a;
    mag_b    = sign_b ? -op_b : op_b;
    is_div   = funct3[2];
    div_zero = is_div && (op_b == '0);
    div_ovf  = is_div && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
  end

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    mul_step  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_q};
    // A borrow out of the trial subtract means the divisor did not fit: restore.
    div_step  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  always_comb begin
    fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    sgna_d   = sgna_q;
    acc_d    = acc_q;
    b_d      = b_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          f3_d   = funct3;
          neg_d  = sign_a ^ sign_b;
          sgna_d = sign_a;
          cnt_d  = '0;
          if (div_zero) begin
            result_d = funct3[1] ? op_a : '1;
            state_d  = DONE;
          end else if (div_ovf) begin
            result_d = funct3[1] ? '0 : op_a;
            state_d  = DONE;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!is_div) begin
            result_d = finalize(funct3, fast_prod, sign_a ^ sign_b, sign_a);
            state_d  = DONE;
`endif
          end else begin
            // Multiply walks the multiplier out of acc_lo; divide shifts the dividend out of it.
            acc_d   = {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
            b_d     = is_div ? mag_b : mag_a;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = f3_q[2] ? div_step : mul_step;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            result_d = finalize(f3_q, f3_q[2] ? div_step : mul_step, neg_q, sgna_q);
            state_d  = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      sgna_q   <= 1'b0;
      acc_q    <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      sgna_q   <= sgna_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule
